// File: rtl/l1ca_acq_scheduler_pkg.sv
// Shared GNSS types and constants for the L1 C/A acquisition scheduler.
package common_gnss_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CODE_W = 11;
  localparam int unsigned DOP_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [4:0]        sv_t;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    WAIT_DONE,
    EVAL,
    ASSIGN
  } acq_sched_state_t;

  localparam word_t ACQ_THRESH_DEFAULT = 32'd1000;

endpackage

// File: rtl/l1ca_acq_scheduler_prio.sv
// Lowest-set-bit priority encoder: idx_o is the index of the lowest set bit of req_i.
module prio_enc_lsb #(
  parameter  int unsigned W  = 4,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    for (int unsigned i = W; i > 0; i--) begin
      if (req_i[i-1]) begin
        idx_o = IW'(i - 1);
      end
    end
  end

endmodule

// File: rtl/l1ca_acq_scheduler.sv
// Acquisition scheduler: walks all PRNs, launches one l1ca_search per untracked PRN
// while a tracking channel is free, and hands hits to the lowest free channel.
module l1ca_acq_scheduler
  import common_gnss_types_pkg::*;
#(
  parameter  int unsigned N_SV   = 32,
  parameter  int unsigned N_CHAN = 4,
  localparam int unsigned SVW    = (N_SV > 1) ? $clog2(N_SV) : 1,
  localparam int unsigned CW     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  word_t             thresh,
  input  logic [N_CHAN-1:0] chan_free,
  input  logic [N_SV-1:0]   sv_tracked,
  output logic              search_start,
  output logic [SVW-1:0]    search_sv,
  input  logic              search_busy,
  input  word_t             search_acc,
  input  logic [CODE_W-1:0] search_code,
  input  logic [DOP_W-1:0]  search_dop,
  output logic              assign_valid,
  output logic [CW-1:0]     assign_chan,
  output logic [SVW-1:0]    assign_sv,
  output logic [CODE_W-1:0] assign_code,
  output logic [DOP_W-1:0]  assign_dop,
  output logic              scan_done,
  output logic              busy,
  output logic [15:0]       drop_cnt
);

  acq_sched_state_t  state_q, state_d;
  logic [SVW-1:0]    sv_ptr_q, sv_ptr_d;
  logic [SVW-1:0]    search_sv_q, search_sv_d;
  logic              assign_valid_q, assign_valid_d;
  logic [CW-1:0]     assign_chan_q, assign_chan_d;
  logic [SVW-1:0]    assign_sv_q, assign_sv_d;
  logic [CODE_W-1:0] assign_code_q, assign_code_d;
  logic [DOP_W-1:0]  assign_dop_q, assign_dop_d;
  logic              scan_done_q, scan_done_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]     free_idx;
  logic              free_any;
  logic              hit;
  logic              advance;

  prio_enc_lsb #(.W(N_CHAN)) u_chan_sel (
    .req_i (chan_free),
    .idx_o (free_idx),
    .any_o (free_any)
  );

  assign hit = search_acc > thresh;

  // Next-state, pointer and registered-output logic for the scheduler FSM.
  always_comb begin
    state_d        = state_q;
    sv_ptr_d       = sv_ptr_q;
    search_sv_d    = search_sv_q;
    assign_valid_d = 1'b0;
    assign_chan_d  = assign_chan_q;
    assign_sv_d    = assign_sv_q;
    assign_code_d  = assign_code_q;
    assign_dop_d   = assign_dop_q;
    scan_done_d    = 1'b0;
    drop_cnt_d     = drop_cnt_q;
    advance        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = SELECT;
      end
      SELECT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (!free_any) begin
          state_d = SELECT;
        end else if (sv_tracked[sv_ptr_q]) begin
          advance = 1'b1;
        end else begin
          search_sv_d = sv_ptr_q;
          state_d     = START;
        end
      end
      START: begin
        if (search_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!search_busy) state_d = EVAL;
      end
      EVAL: begin
        if (hit && free_any) begin
          // Payload is registered here so it is valid together with the pulse in ASSIGN.
          assign_valid_d = 1'b1;
          assign_chan_d  = free_idx;
          assign_sv_d    = search_sv_q;
          assign_code_d  = search_code;
          assign_dop_d   = search_dop;
          state_d        = ASSIGN;
        end else begin
          if (hit && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
          advance = 1'b1;
          state_d = SELECT;
        end
      end
      ASSIGN: begin
        advance = 1'b1;
        state_d = SELECT;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (sv_ptr_q == SVW'(N_SV - 1)) begin
        sv_ptr_d    = '0;
        scan_done_d = 1'b1;
      end else begin
        sv_ptr_d = sv_ptr_q + SVW'(1);
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      sv_ptr_q       <= '0;
      search_sv_q    <= '0;
      assign_valid_q <= 1'b0;
      assign_chan_q  <= '0;
      assign_sv_q    <= '0;
      assign_code_q  <= '0;
      assign_dop_q   <= '0;
      scan_done_q    <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      sv_ptr_q       <= sv_ptr_d;
      search_sv_q    <= search_sv_d;
      assign_valid_q <= assign_valid_d;
      assign_chan_q  <= assign_chan_d;
      assign_sv_q    <= assign_sv_d;
      assign_code_q  <= assign_code_d;
      assign_dop_q   <= assign_dop_d;
      scan_done_q    <= scan_done_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign search_start = (state_q == START);
  assign busy         = (state_q != IDLE);
  assign search_sv    = search_sv_q;
  assign assign_valid = assign_valid_q;
  assign assign_chan  = assign_chan_q;
  assign assign_sv    = assign_sv_q;
  assign assign_code  = assign_code_q;
  assign assign_dop   = assign_dop_q;
  assign scan_done    = scan_done_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_l1ca_acq_scheduler.sv
// Directed bench for l1ca_acq_scheduler with a behavioural l1ca_search model.
module tb_l1ca_acq_scheduler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic [31:0] thresh;
  logic [3:0]  chan_free;
  logic [31:0] sv_tracked;
  logic        search_start;
  logic [4:0]  search_sv;
  logic        search_busy;
  logic [31:0] search_acc;
  logic [10:0] search_code;
  logic [4:0]  search_dop;
  logic        assign_valid;
  logic [1:0]  assign_chan;
  logic [4:0]  assign_sv;
  logic [10:0] assign_code;
  logic [4:0]  assign_dop;
  logic        scan_done;
  logic        busy;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int assign_cnt = 0;
  int mcnt;
  logic start_prev = 1'b0;

  int          exp_starts[$];
  int          obs_starts[$];
  logic [22:0] exp_assign[$];
  logic [22:0] obs_assign[$];
  int          scan_cyc[$];

  l1ca_acq_scheduler #(.N_SV(32), .N_CHAN(4)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .thresh       (thresh),
    .chan_free    (chan_free),
    .sv_tracked   (sv_tracked),
    .search_start (search_start),
    .search_sv    (search_sv),
    .search_busy  (search_busy),
    .search_acc   (search_acc),
    .search_code  (search_code),
    .search_dop   (search_dop),
    .assign_valid (assign_valid),
    .assign_chan  (assign_chan),
    .assign_sv    (assign_sv),
    .assign_code  (assign_code),
    .assign_dop   (assign_dop),
    .scan_done    (scan_done),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  // l1ca_search model: busy rises ~2 cycles after start, stays high 50 cycles.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mcnt        <= 0;
      search_busy <= 1'b0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt + 1;
      if (mcnt == 2) search_busy <= 1'b1;
      if (mcnt == 52) begin
        search_busy <= 1'b0;
        mcnt        <= 0;
      end
    end else if (search_start && !search_busy) begin
      mcnt <= 1;
    end
  end

  // Monitor: collect search launches, assignments and scan_done pulses.
  always @(negedge clk) begin
    cyc++;
    if (!nrst) begin
      start_prev = 1'b0;
    end else begin
      if (search_start && !start_prev) obs_starts.push_back(int'(search_sv));
      start_prev = search_start;
      if (assign_valid) begin
        assign_cnt++;
        obs_assign.push_back({assign_chan, assign_sv, assign_code, assign_dop});
      end
      if (scan_done) scan_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_start(input string tag, input int sv);
    int got;
    int want;
    exp_starts.push_back(sv);
    for (int i = 0; i < 400 && obs_starts.size() == 0; i++) @(negedge clk);
    want = exp_starts.pop_front();
    check({tag, "_seen"}, 64'(obs_starts.size() != 0), 64'd1);
    if (obs_starts.size() != 0) begin
      got = obs_starts.pop_front();
      check(tag, 64'(got), 64'(want));
    end
  endtask

  task automatic wait_search_busy(input string tag);
    for (int i = 0; i < 20 && !search_busy; i++) @(negedge clk);
    check(tag, 64'(search_busy), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [22:0] got_a;
    nrst = 1'b0; en = 1'b0; thresh = 32'd100; chan_free = 4'h0; sv_tracked = '0;
    search_acc = '0; search_code = '0; search_dop = '0;
    idle_cycles(3);
    #1 nrst = 1'b1;

    // Reset state
    idle_cycles(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(search_start), 64'd0);
    check("rst_assign_valid", 64'(assign_valid), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_scan_done", 64'(scan_done), 64'd0);

    // Skip tracked PRNs, all misses
    sv_tracked = 32'hFFFF_FFF0; chan_free = 4'hF; search_acc = 32'd50; thresh = 32'd100;
    scan_cyc.delete();
    en = 1'b1;
    expect_start("skip_0", 0);
    expect_start("skip_1", 1);
    expect_start("skip_2", 2);
    expect_start("skip_3", 3);
    check("skip_no_wrap_yet", 64'(scan_cyc.size()), 64'd0);
    expect_start("skip_0b", 0);
    check("skip_wrap_once", 64'(scan_cyc.size()), 64'd1);

    // en dropped in WAIT_DONE: search completes, then IDLE
    wait_search_busy("en0_busy_up");
    idle_cycles(3);
    en = 1'b0;
    wait_idle("en0_idle");
    idle_cycles(10);
    check("en0_no_new_start", 64'(obs_starts.size()), 64'd0);
    check("en0_no_assign", 64'(assign_cnt), 64'd0);

    // Hit on PRN 5 (pointer advanced to 1 by the evaluated search above)
    sv_tracked = ~(32'd1 << 5); chan_free = 4'b1010;
    search_acc = 32'd1000; thresh = 32'd999; search_code = 11'd700; search_dop = 5'd12;
    exp_assign.push_back({2'd1, 5'd5, 11'd700, 5'd12});
    en = 1'b1;
    expect_start("hit_sv", 5);
    for (int i = 0; i < 200 && obs_assign.size() == 0; i++) @(negedge clk);
    sv_tracked = '1;
    check("hit_assign_seen", 64'(obs_assign.size()), 64'd1);
    if (obs_assign.size() != 0) begin
      got_a = obs_assign.pop_front();
      check("hit_payload", 64'(got_a), 64'(exp_assign.pop_front()));
    end

    // Fully tracked: scan_done every 32 cycles, no launches
    scan_cyc.delete();
    for (int i = 0; i < 200 && scan_cyc.size() < 3; i++) @(negedge clk);
    check("full_scan_pulses", 64'(scan_cyc.size() >= 3), 64'd1);
    if (scan_cyc.size() >= 3) begin
      check("full_period_a", 64'(scan_cyc[1] - scan_cyc[0]), 64'd32);
      check("full_period_b", 64'(scan_cyc[2] - scan_cyc[1]), 64'd32);
    end
    check("full_no_start", 64'(obs_starts.size()), 64'd0);
    check("hit_single_pulse", 64'(assign_cnt), 64'd1);
    check("assign_hold_sv", 64'(assign_sv), 64'd5);
    check("assign_hold_code", 64'(assign_code), 64'd700);

    // Boundary: acc == thresh is a miss, pointer still advances
    search_acc = 32'd999; thresh = 32'd999; chan_free = 4'hF;
    sv_tracked = ~(32'd1 << 9);
    expect_start("eq_sv9", 9);
    sv_tracked = ~((32'd1 << 9) | (32'd1 << 10));
    expect_start("eq_sv10", 10);
    en = 1'b0; sv_tracked = '1;
    wait_idle("eq_idle");
    check("eq_no_assign", 64'(assign_cnt), 64'd1);
    check("eq_no_drop", 64'(drop_cnt), 64'd0);

    // No free channel: no launch; channel lost during search -> drop
    sv_tracked = ~(32'd1 << 12); chan_free = 4'h0; search_acc = 32'd1000;
    en = 1'b1;
    idle_cycles(100);
    check("nochan_no_start", 64'(obs_starts.size()), 64'd0);
    check("nochan_busy", 64'(busy), 64'd1);
    chan_free = 4'hF;
    expect_start("drop_sv", 12);
    sv_tracked = '1;
    wait_search_busy("drop_busy_up");
    chan_free = 4'h0;
    for (int i = 0; i < 200 && drop_cnt == 16'd0; i++) @(negedge clk);
    idle_cycles(5);
    check("drop_cnt", 64'(drop_cnt), 64'd1);
    check("drop_no_assign", 64'(assign_cnt), 64'd1);
    en = 1'b0; chan_free = 4'hF;
    wait_idle("drop_idle");

    // Reset mid-WAIT_DONE clears outputs without a clock edge
    sv_tracked = ~(32'd1 << 20); en = 1'b1;
    expect_start("rst_mid_sv", 20);
    wait_search_busy("rst_mid_busy_up");
    idle_cycles(5);
    check("pre_rst_search_sv", 64'(search_sv), 64'd20);
    #1 nrst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_start", 64'(search_start), 64'd0);
    check("mid_rst_search_sv", 64'(search_sv), 64'd0);
    check("mid_rst_assign_chan", 64'(assign_chan), 64'd0);
    check("mid_rst_assign_sv", 64'(assign_sv), 64'd0);
    check("mid_rst_assign_code", 64'(assign_code), 64'd0);
    check("mid_rst_assign_dop", 64'(assign_dop), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt), 64'd0);
    check("mid_rst_scan_done", 64'(scan_done), 64'd0);
    check("mid_rst_assign_valid", 64'(assign_valid), 64'd0);
    en = 1'b0;
    idle_cycles(2);
    #1 nrst = 1'b1;
    idle_cycles(10);
    check("post_rst_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
